pwl_delay_ctrl: RTL and testbench

//  Clocked sequencer that produces the real-valued `delay` input of a pwl delay primitive.

---
 rtl/pwl_delay_ctrl.sv | 97 +++++++++
 tb/tb_pwl_delay_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pwl_delay_ctrl.sv
// pwl_delay_ctrl: slews a pwl delay code toward a requested target at STEP/clk, settles, then acks.
// Build option PWL_DELAY_CTRL_SATURATE_EN clamps out-of-range targets instead of rejecting them.
module pwl_delay_ctrl #(
  parameter int  NB         = 6,
  parameter int  CODE_MAX   = 40,
  parameter int  CODE_INIT  = 0,
  parameter int  STEP       = 1,
  parameter int  SETTLE_CYC = 4,
  parameter real DLY_MIN    = 10e-12,
  parameter real DLY_LSB    = 1e-12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [NB-1:0] tgt_code_i,
  output logic          ack_o,
  output logic          busy_o,
  output logic          err_o,
  output logic [NB-1:0] code_o,
  output real           delay_o
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [NB-1:0] MAXC = NB'(CODE_MAX);
  localparam logic [NB-1:0] INITC = NB'(CODE_INIT);
  localparam logic [NB:0] ST = (NB + 1)'(STEP);
  localparam logic [CW-1:0] CSET = CW'(SETTLE_CYC - 1);
  typedef enum logic [1:0] {IDLE, SLEW, SETTLE, ACK} state_t;
  state_t state_q, state_d;
  logic [NB-1:0] code_q, code_d, tgt_q, tgt_d, acc_tgt, code_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, over, reject;
  logic signed [NB:0] diff;
  logic [NB:0] mag, lim;
  assign over = tgt_code_i > MAXC;
`ifdef PWL_DELAY_CTRL_SATURATE_EN
  assign acc_tgt = over ? MAXC : tgt_code_i;
  assign reject  = 1'b0;
`else
  assign acc_tgt = tgt_code_i;
  assign reject  = over;
`endif
  // signed difference one bit wider than the code so the direction is never ambiguous
  assign diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, code_q});
  assign mag      = diff[NB] ? -diff : diff;
  assign lim      = mag > ST ? ST : mag;
  assign code_nxt = diff[NB] ? code_q - lim[NB-1:0] : code_q + lim[NB-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= INITC;
      tgt_q   <= INITC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE:
        if (req_i && reject) begin
          state_d = ACK;
          err_d   = 1'b1;
        end else if (req_i) begin
          tgt_d   = acc_tgt;
          state_d = acc_tgt == code_q ? SETTLE : SLEW;
          cnt_d   = CSET;
        end
      SLEW: begin
        code_d  = code_nxt;
        state_d = code_nxt == tgt_q ? SETTLE : SLEW;
        cnt_d   = CSET;
      end
      SETTLE: begin
        state_d = cnt_q == '0 ? ACK : SETTLE;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = req_i ? ACK : IDLE;
    endcase
  end
  always_comb begin
    ack_o   = state_q == ACK;
    busy_o  = state_q == SLEW || state_q == SETTLE;
    err_o   = err_q;
    code_o  = code_q;
    delay_o = DLY_MIN + DLY_LSB * real'(code_q);
  end
endmodule

// File: tb/tb_pwl_delay_ctrl.sv
// tb_pwl_delay_ctrl: two instances (STEP=1 and STEP=4) driven by random requests, checked per cycle
// against an arithmetic model of code trajectory and ack timing.
module tb_pwl_delay_ctrl;
  localparam int SET = 4;
  localparam int CMAX = 40;
  localparam int STEPS [2] = '{1, 4};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req [2];
  logic [5:0] tgt [2];
  logic ack [2], busy [2], err [2];
  logic [5:0] code [2];
  real dly [2];
  int mcode [2];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pwl_delay_ctrl #(.STEP(1)) dut0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .tgt_code_i(tgt[0]), .ack_o(ack[0]),
    .busy_o(busy[0]), .err_o(err[0]), .code_o(code[0]), .delay_o(dly[0])
  );
  pwl_delay_ctrl #(.STEP(4)) dut1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .tgt_code_i(tgt[1]), .ack_o(ack[1]),
    .busy_o(busy[1]), .err_o(err[1]), .code_o(code[1]), .delay_o(dly[1])
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input int k, input string tag, input int ec, input bit eb, input bit ea, input bit ee);
    real ed, df;
    ed = 10e-12 + real'(ec) * 1e-12;
    df = dly[k] - ed;
    chk($sformatf("%s.u%0d.code", tag, k), 32'(code[k]), 32'(ec));
    chk($sformatf("%s.u%0d.busy", tag, k), 32'(busy[k]), 32'(eb));
    chk($sformatf("%s.u%0d.ack", tag, k), 32'(ack[k]), 32'(ea));
    chk($sformatf("%s.u%0d.err", tag, k), 32'(err[k]), 32'(ee));
    chk($sformatf("%s.u%0d.delay_ps_x1000", tag, k), 32'($rtoi(dly[k] * 1e15)), 32'($rtoi(ed * 1e15)));
    chk($sformatf("%s.u%0d.delay_ok", tag, k), 32'(df < 1e-16 && df > -1e-16), 32'd1);
  endtask
  task automatic op(input int k, input int t_in, input int hold, input bit drop_early);
    int c, t, d, s, n, mv;
    bit rej;
    c = mcode[k];
`ifdef PWL_DELAY_CTRL_SATURATE_EN
    rej = 1'b0;
    t = t_in > CMAX ? CMAX : t_in;
`else
    rej = t_in > CMAX;
    t = t_in;
`endif
    req[k] = 1'b1;
    tgt[k] = 6'(t_in);
    tick;
    if (rej) begin
      chk_all(k, "reject", c, 0, 1, 1);
      tick;
      chk_all(k, "reject_hold", c, 0, 1, 0);
      req[k] = 1'b0;
      tick;
      chk_all(k, "reject_idle", c, 0, 0, 0);
      return;
    end
    d = t > c ? t - c : c - t;
    s = t > c ? 1 : -1;
    n = (d + STEPS[k] - 1) / STEPS[k];
    chk_all(k, "accept", c, 1, 0, 0);
    for (int i = 1; i <= n + SET; i++) begin
      tgt[k] = 6'($urandom_range(0, 63));
      if (drop_early) req[k] = 1'b0;
      tick;
      mv = i * STEPS[k] < d ? i * STEPS[k] : d;
      chk_all(k, "run", c + s * mv, i < n + SET, i == n + SET, 0);
    end
    mcode[k] = t;
    if (drop_early) begin
      tick;
      chk_all(k, "drop_idle", t, 0, 0, 0);
    end else begin
      repeat (hold) begin
        tick;
        chk_all(k, "ack_hold", t, 0, 1, 0);
      end
      req[k] = 1'b0;
      tick;
      chk_all(k, "release", t, 0, 0, 0);
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0;
      tgt[k] = 6'd0;
      mcode[k] = 0;
    end
    #1;
    chk_all(0, "reset", 0, 0, 0, 0);
    chk_all(1, "reset", 0, 0, 0, 0);
    tick;
    rst = 1'b0;
    repeat (3) begin
      tgt[0] = 6'($urandom_range(0, 63));
      tick;
      chk_all(0, "idle", 0, 0, 0, 0);
    end
    op(0, 5, 10, 1'b0);
    op(1, 5, 2, 1'b0);
    op(1, 0, 1, 1'b0);
    op(0, 50, 0, 1'b0);
    op(1, 63, 1, 1'b0);
    op(0, 40, 0, 1'b1);
    op(0, 40, 1, 1'b0);
    for (int r = 0; r < 25; r++) begin
      op(r % 2, int'($urandom_range(0, 47)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    op(0, 0, 0, 1'b0);
    req[0] = 1'b1;
    tgt[0] = 6'd10;
    tick;
    repeat (3) tick;
    chk_all(0, "pre_abort", 3, 1, 0, 0);
    rst = 1'b1;
    #1;
    mcode[0] = 0;
    mcode[1] = 0;
    chk_all(0, "abort", 0, 0, 0, 0);
    chk_all(1, "abort", 0, 0, 0, 0);
    req[0] = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk_all(0, "post_abort", 0, 0, 0, 0);
    op(0, 7, 1, 1'b0);
    op(1, 33, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
